// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with program counter, memory request handshake and prefetch queue
//
// Owns the fetch address and issues one byte read at a time to program memory.
// Returned bytes go into a FIFO of {addr, byte} entries. The head entry is
// presented on instr/pc for the controller to consume with fetch.
//
// Build option: define IFETCH_PREFETCH_EN for a two-entry queue. Leave it
// undefined for a single instruction register, which requests only when empty.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   rst          in   synchronous active-high reset
//   fetch        in   consume strobe; pops the head entry when instr_valid
//   jump         in   redirect strobe; flushes the queue, refetches from jump_addr
//   jump_addr    in   redirect target [15:0]
//   mem_req      out  memory read request
//   mem_addr     out  read address [15:0], held while a request is unacked
//   mem_ack      in   memory acknowledge; mem_data is valid in the same cycle
//   mem_data     in   read data [7:0]
//   instr        out  head-of-queue byte [7:0]
//   instr_valid  out  queue non-empty
//   pc           out  address of the head byte [15:0]; holds last head address when empty

module ifetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  instr,
  output logic        instr_valid,
  output logic [15:0] pc
);

`ifdef IFETCH_PREFETCH_EN
  localparam int QN = 2;
`else
  localparam int QN = 1;
`endif
  localparam logic [1:0] DEPTH = 2'(QN);

  // Entry 0 is always the head, so instr/pc come straight from flops.
  logic [15:0] q_addr   [QN];
  logic [7:0]  q_data   [QN];
  logic [15:0] q_addr_d [QN];
  logic [7:0]  q_data_d [QN];
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic [15:0] addr_d;
  logic        req_d;
  logic        push;
  logic        pop;
  logic [1:0]  wr_idx;

  always_comb begin
    q_addr_d = q_addr;
    q_data_d = q_data;
    count_d  = count_q;
    addr_d   = mem_addr;

    // A jump discards both a same-cycle ack and a same-cycle fetch.
    push   = mem_req && mem_ack && !jump;
    pop    = fetch && (count_q != 2'd0) && !jump;
    wr_idx = count_q - {1'b0, pop};

    if (jump) begin
      count_d = 2'd0;
      addr_d  = jump_addr;
    end else begin
      // Popping the last entry leaves entry 0 untouched so pc keeps the
      // last head address while the queue is empty.
      if (pop && (count_q > 2'd1)) begin
        for (int i = 0; i < QN - 1; i++) begin
          q_addr_d[i] = q_addr[i+1];
          q_data_d[i] = q_data[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < QN; i++) begin
          if (wr_idx == 2'(i)) begin
            q_addr_d[i] = mem_addr;
            q_data_d[i] = mem_data;
          end
        end
        addr_d = mem_addr + 16'd1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Only one request is ever outstanding: while it is unacked nothing can
    // raise the count, so req_d stays high and addr_d stays put unless a
    // jump retargets it.
    req_d = (count_d < DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      for (int i = 0; i < QN; i++) begin
        q_addr[i] <= RESET_PC;
        q_data[i] <= 8'h00;
      end
    end else begin
      count_q  <= count_d;
      mem_req  <= req_d;
      mem_addr <= addr_d;
      q_addr   <= q_addr_d;
      q_data   <= q_data_d;
    end
  end

  assign instr       = q_data[0];
  assign pc          = q_addr[0];
  assign instr_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch against a byte-stream reference model

module tb_ifetch;

`ifdef IFETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [15:0] pc;

  ifetch dut (
    .clk(clk),
    .rst(rst),
    .fetch(fetch),
    .jump(jump),
    .jump_addr(jump_addr),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .instr(instr),
    .instr_valid(instr_valid),
    .pc(pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_addr = 16'h0000;

  // Program memory contents: a fixed function of the address.
  function automatic logic [7:0] fmem(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'hA0;
  endfunction

  // Memory model: acks `lat` cycles after a request (or retarget) appears,
  // returning the byte for the address present at the ack edge.
  int          lat = 0;
  bit          mem_en = 1'b1;
  int          wcnt = 0;
  bit          prev_req = 1'b0;
  logic [15:0] last_addr = 16'h0000;

  always @(negedge clk) begin
    if (rst || !mem_req || !mem_en) begin
      mem_ack = 1'b0;
      wcnt = 0;
      prev_req = 1'b0;
    end else begin
      if (mem_ack || !prev_req || mem_addr != last_addr) wcnt = 0;
      else wcnt++;
      mem_ack = (wcnt >= lat);
      prev_req = 1'b1;
    end
    last_addr = mem_addr;
    mem_data = fmem(mem_addr);
  end

  task automatic test_reset();
    rst = 1'b1;
    fetch = 1'b0;
    jump = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    n_checks++;
    if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %0b want 0", instr_valid); end
    n_checks++;
    if (instr !== 8'h00) begin n_fail++; $display("FAIL reset_instr got %h want 00", instr); end
    n_checks++;
    if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL release_mem_req got %0b want 1", mem_req); end
    exp_addr = 16'h0000;
  endtask

  task automatic test_fill();
    logic [7:0]  fill_exp [2];
    logic [15:0] a;
    fill_exp[0] = 8'hA0;
    fill_exp[1] = 8'hA1;
    lat = 0;
    fetch = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid got %0b want 1", instr_valid); end
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fill_mem_req got %0b want 0", mem_req); end
    n_checks++;
    if (mem_addr !== 16'(D)) begin n_fail++; $display("FAIL fill_mem_addr got %h want %h", mem_addr, 16'(D)); end
    mem_en = 1'b0;
    for (int k = 0; k < D; k++) begin
      a = 16'(k);
      n_checks++;
      if (instr !== fill_exp[k] || pc !== a)
        begin n_fail++; $display("FAIL fill_head%0d got %h@%h want %h@%h", k, instr, pc, fill_exp[k], a); end
      fetch = 1'b1;
      @(negedge clk);
      #1;
      fetch = 1'b0;
    end
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid got %0b want 0", instr_valid); end
    n_checks++;
    if (pc !== 16'(D - 1)) begin n_fail++; $display("FAIL drained_pc_hold got %h want %h", pc, 16'(D - 1)); end
    mem_en = 1'b1;
    exp_addr = 16'(D);
  endtask

  task automatic test_back_to_back();
    int  popped = 0;
    bit  seen = 1'b0;
    lat = 0;
    fetch = 1'b0;
    jump = 1'b1;
    jump_addr = 16'h0100;
    @(negedge clk);
    #1;
    jump = 1'b0;
    exp_addr = 16'h0100;
    fetch = 1'b1;
    for (int c = 0; c < 40 && popped < 6; c++) begin
      @(negedge clk);
      #1;
`ifdef IFETCH_PREFETCH_EN
      if (seen) begin
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got valid %0b want 1", instr_valid); end
      end
`else
      n_checks++;
      if (instr_valid && mem_req) begin n_fail++; $display("FAIL b2b_req_while_valid got req 1 want 0"); end
`endif
      if (instr_valid) begin
        n_checks++;
        if (pc !== exp_addr || instr !== fmem(exp_addr))
          begin n_fail++; $display("FAIL b2b_head got %h@%h want %h@%h", instr, pc, fmem(exp_addr), exp_addr); end
        exp_addr++;
        popped++;
        seen = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    fetch = 1'b0;
    n_checks++;
    if (popped < 6) begin n_fail++; $display("FAIL b2b_timeout got %0d bytes want 6", popped); end
  endtask

  task automatic test_jump_wait();
    int popped = 0;
    fetch = 1'b0;
    lat = 3;
    jump = 1'b1;
    jump_addr = 16'h0200;
    @(negedge clk);
    #1;
    jump = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_ack !== 1'b0 || mem_addr !== 16'h0200)
      begin n_fail++; $display("FAIL jw_pending got req %0b ack %0b addr %h want 1 0 0200", mem_req, mem_ack, mem_addr); end
    jump = 1'b1;
    jump_addr = 16'h1234;
    @(negedge clk);
    #1;
    jump = 1'b0;
    exp_addr = 16'h1234;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h1234)
      begin n_fail++; $display("FAIL jw_retarget got req %0b addr %h want 1 1234", mem_req, mem_addr); end
    fetch = 1'b1;
    for (int c = 0; c < 60 && popped < 3; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid) begin
        n_checks++;
        if (pc !== exp_addr || instr !== fmem(exp_addr))
          begin n_fail++; $display("FAIL jw_head got %h@%h want %h@%h", instr, pc, fmem(exp_addr), exp_addr); end
        exp_addr++;
        popped++;
      end
    end
    @(negedge clk);
    #1;
    fetch = 1'b0;
    n_checks++;
    if (popped < 3) begin n_fail++; $display("FAIL jw_timeout got %0d bytes want 3", popped); end
  endtask

  task automatic test_wrap();
    int popped = 0;
    lat = 0;
    fetch = 1'b0;
    jump = 1'b1;
    jump_addr = 16'hFFFF;
    @(negedge clk);
    #1;
    jump = 1'b0;
    exp_addr = 16'hFFFF;
    fetch = 1'b1;
    for (int c = 0; c < 40 && popped < 3; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid) begin
        n_checks++;
        if (pc !== exp_addr || instr !== fmem(exp_addr))
          begin n_fail++; $display("FAIL wrap_head got %h@%h want %h@%h", instr, pc, fmem(exp_addr), exp_addr); end
        exp_addr++;
        popped++;
      end
    end
    @(negedge clk);
    #1;
    fetch = 1'b0;
    n_checks++;
    if (popped < 3) begin n_fail++; $display("FAIL wrap_timeout got %0d bytes want 3", popped); end
  endtask

  task automatic test_random();
    bit          pend = 1'b0;
    logic [15:0] hold_addr = 16'h0000;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      #1;
      if (pend) begin
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== hold_addr)
          begin n_fail++; $display("FAIL rnd_stable got req %0b addr %h want 1 %h", mem_req, mem_addr, hold_addr); end
      end
`ifndef IFETCH_PREFETCH_EN
      n_checks++;
      if (instr_valid && mem_req) begin n_fail++; $display("FAIL rnd_req_while_valid got req 1 want 0"); end
`endif
      jump = ($urandom_range(0, 99) < 3);
      fetch = ($urandom_range(0, 99) < 60);
      if (jump) begin
        jump_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
        lat = $urandom_range(0, 3);
      end
      if (instr_valid && fetch && !jump) begin
        n_checks++;
        if (pc !== exp_addr || instr !== fmem(exp_addr))
          begin n_fail++; $display("FAIL rnd_head got %h@%h want %h@%h", instr, pc, fmem(exp_addr), exp_addr); end
        exp_addr++;
      end
      if (jump) exp_addr = jump_addr;
      pend = mem_req && !mem_ack && !jump;
      hold_addr = mem_addr;
    end
    @(negedge clk);
    #1;
    fetch = 1'b0;
    jump = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_jump_wait();
    test_wrap();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
